instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output queue depth in words (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request can be accepted this cycle.
REQ-006 SHALL have port in_op  input  4  mnemonic code: INCRI=0000, INCRJ=0001, SETN=0010, SUMFV=0011, MULFV=0100, NOP=0101, LDV=0110.
REQ-007 SHALL have port in_sel  input  1  register/vector select operand.
REQ-008 SHALL have port in_imm  input  32  immediate operand, unsigned.
REQ-009 SHALL have port out_valid  output  1  encoded word available.
REQ-010 SHALL have port out_ready  input  1  consumer (instr_decoder side) takes word.
REQ-011 SHALL have port out_instr  output  32  encoded instruction word.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  words held.
REQ-013 SHALL have port err_illegal  output  1  one-cycle pulse, illegal op rejected.
REQ-014 SHALL have port err_imm  output  1  one-cycle pulse, immediate truncated (only with IMM_CHECK_EN).

Function
REQ-015 SHALL encode word as: [31:28]=in_op, [27]=sel field, [26:25]=00, [24:0]=imm field.
REQ-016 SHALL drive sel field = in_sel only for MULFV and LDV, else 0.
REQ-017 SHALL drive imm field = in_imm[24:0] only for SETN, else 0.
REQ-018 SHALL accept a request on a cycle with in_valid && in_ready; in_ready = (count != DEPTH).
REQ-019 SHALL treat in_op 0111..1111 as illegal: handshake completes, nothing queued, err_illegal high the next cycle for exactly one cycle.
REQ-020 SHALL store accepted legal words in FIFO order; out_instr = head word (show-ahead), out_valid = (count != 0).
REQ-021 SHALL pop head on out_valid && out_ready.
REQ-022 SHALL have latency 1: word accepted at edge N is visible on out_instr after edge N when queue was empty.
REQ-023 SHALL keep count unchanged on simultaneous push and pop; push when full impossible (in_ready low); pop when empty ignored.
REQ-024 SHALL wrap read/write pointers modulo DEPTH.
REQ-025 SHALL hold out_instr stable while out_valid && !out_ready.

Reset
REQ-026 SHALL on rst clear pointers and count: count=0, out_valid=0, in_ready=1, err_illegal=0, err_imm=0, out_instr=0.
REQ-027 SHALL give rst priority over any handshake in the same cycle; queued words discarded mid-operation.

Configuration
REQ-028 SHALL, with IMM_CHECK_EN defined, pulse err_imm one cycle after accepting a SETN whose in_imm[31:25] != 0 (word still queued, truncated).
REQ-029 SHALL, without IMM_CHECK_EN, omit the check logic and tie err_imm to 0.

Structure
REQ-030 SHALL place opcode enum (4-bit), field bit positions, and IMM_W=25 in shared package instr_pkg, also used by instr_decoder.
REQ-031 SHALL implement storage as sub-module instr_fifo (parameter DEPTH, WIDTH=32); encoding logic stays in instr_encoder.

Verification
REQ-032 SHALL verify: push SETN imm=400 to empty queue -> next cycle out_valid=1, out_instr=32'h2000_0190.
REQ-033 SHALL verify: push MULFV sel=1 imm=5, then LDV sel=1, out_ready=1 -> out_instr 32'h4800_0000 then 32'h6800_0000, imm ignored.
REQ-034 SHALL verify: out_ready=0, push 5 legal ops with DEPTH=4 -> in_ready=0 after 4th, count=4, 5th stalls until one pop.
REQ-035 SHALL verify: push in_op=1010 -> err_illegal pulses once, count unchanged, in_ready stays 1.
REQ-036 SHALL verify: with IMM_CHECK_EN, SETN imm=32'h0200_0001 -> err_imm pulse, out_instr=32'h2000_0001; without macro err_imm=0.
REQ-037 SHALL verify: rst asserted with count=3 and simultaneous push -> next cycle count=0, out_valid=0, pushed word lost.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared opcode and field layout for instr_encoder / instr_decoder.
package instr_pkg;

    typedef enum logic [3:0] {
        OP_INCRI = 4'b0000,
        OP_INCRJ = 4'b0001,
        OP_SETN  = 4'b0010,
        OP_SUMFV = 4'b0011,
        OP_MULFV = 4'b0100,
        OP_NOP   = 4'b0101,
        OP_LDV   = 4'b0110
    } op_e;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int SEL_BIT = 27;
    localparam int IMM_W   = 25;

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead word FIFO; out-of-range push/pop requests are ignored.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head reads as zero when empty so reset state shows a clean word.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes op requests into 32-bit words and queues them for the decoder.
// Optional IMM_CHECK_EN flags SETN immediates that do not fit 25 bits.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic                     in_sel,
    input  logic [31:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_illegal,
    output logic                     err_imm
);

    logic             legal;
    logic             sel_f;
    logic [IMM_W-1:0] imm_f;
    logic [31:0]      word;
    logic             accept;
    logic             push;
    logic             full;
    logic             empty;

    always_comb begin
        legal = 1'b1;
        sel_f = 1'b0;
        imm_f = '0;
        unique case (in_op)
            OP_MULFV, OP_LDV: sel_f = in_sel;
            OP_SETN:          imm_f = in_imm[IMM_W-1:0];
            OP_INCRI, OP_INCRJ, OP_SUMFV, OP_NOP: ;
            default:          legal = 1'b0;
        endcase
    end

    always_comb begin
        word                 = '0;
        word[OP_MSB:OP_LSB]  = in_op;
        word[SEL_BIT]        = sel_f;
        word[IMM_W-1:0]      = imm_f;
    end

    assign in_ready  = !full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign out_valid = !empty;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (word),
        .pop   (out_ready),
        .rdata (out_instr),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Illegal ops still complete the handshake; they just never reach the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept && !legal;
        end
    end

`ifdef IMM_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_imm <= 1'b0;
        end else begin
            err_imm <= push && (in_op == OP_SETN) && (|in_imm[31:IMM_W]);
        end
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:IMM_W];
    assign err_imm       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4).
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic        in_sel;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [$clog2(DEPTH):0] count;
    logic        err_illegal;
    logic        err_imm;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_sel      (in_sel),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .count       (count),
        .err_illegal (err_illegal),
        .err_imm     (err_imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op,
                                        input logic sel,
                                        input logic [31:0] imm);
        logic [31:0] w;
        w = {op, 28'h0};
        if (op == 4'd4 || op == 4'd6) w = w | (32'(sel) << 27);
        if (op == 4'd2) w = w | (imm & 32'h01ff_ffff);
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", out_instr, 32'hxxxx_xxxx);
            end else begin
                chk("sb_word", out_instr, sb.pop_front());
            end
        end
    end

    task automatic push(input logic [3:0] op, input logic sel,
                        input logic [31:0] imm);
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_sel   = sel;
        in_imm   = imm;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            if (op <= 4'd6) sb.push_back(enc(op, sel, imm));
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_sb", 32'(sb.size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic exp_imm;
`ifdef IMM_CHECK_EN
        exp_imm = 1'b1;
`else
        exp_imm = 1'b0;
`endif
        rst = 1'b1;
        in_valid = 1'b0;
        in_op = '0;
        in_sel = 1'b0;
        in_imm = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_err_ill", 32'(err_illegal), 32'd0);
        chk("rst_err_imm", 32'(err_imm), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        rst = 1'b0;

        push(4'd2, 1'b1, 32'd400);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_instr", out_instr, 32'h2000_0190);
        chk("lat_count", 32'(count), 32'd1);
        drain();

        out_ready = 1'b1;
        push(4'd4, 1'b1, 32'd5);
        push(4'd6, 1'b1, 32'd77);
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(4'(i), 1'b1, 32'(i + 3));
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        fork
            push(4'd5, 1'b0, 32'd9);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stall_count", 32'(count), 32'd4);
                chk("stall_ready", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();

        push(4'b1010, 1'b1, 32'hffff_ffff);
        chk("ill_pulse", 32'(err_illegal), 32'd1);
        chk("ill_count", 32'(count), 32'd0);
        chk("ill_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("ill_clear", 32'(err_illegal), 32'd0);

        out_ready = 1'b0;
        push(4'd2, 1'b0, 32'h0200_0001);
        chk("imm_pulse", 32'(err_imm), 32'(exp_imm));
        chk("imm_instr", out_instr, 32'h2000_0001);
        @(posedge clk);
        #1;
        chk("imm_clear", 32'(err_imm), 32'd0);
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(4'd3, 1'b0, 32'd0);
        chk("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1;
        in_valid = 1'b1;
        in_op = 4'd2;
        in_imm = 32'd7;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_lost", 32'(count), 32'd0);

        fork
            for (int i = 0; i < 12; i++) begin
                push(4'($urandom_range(0, 6)), 1'($urandom),
                     $urandom);
            end
            for (int c = 0; c < 60; c++) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom);
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
